// File: rtl/comparator_fifo_reader.sv
// Read-side drain engine for the comparator capture FIFO: paces reads, parses sync/len/payload(/csum)
// frames and streams payload bytes downstream. Define CMPFIFO_RD_CSUM_EN to build the checksum byte/compare.
module comparator_fifo_reader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 255
) (
    input  logic        rdclk,
    input  logic        aclr,
    input  logic        enable,
    input  logic        fifo_rdempty,
    input  logic [7:0]  fifo_q,
    output logic        fifo_rdreq,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eof,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [1:0]  fsm_state
);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
`ifdef CMPFIFO_RD_CSUM_EN
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
`else
        PAYLOAD = 2'd2
`endif
    } state_t;

    state_t      state, state_next;
    logic        pend;
    logic [1:0]  occ, wr_ptr, rd_ptr;
    logic [9:0]  buf_mem [3];
    logic [7:0]  remaining;
    logic        first;
    logic        push, pop, ok_set, bad_frame, discard, load_len, last;
`ifdef CMPFIFO_RD_CSUM_EN
    logic [7:0]  sum;
`endif

    // Credit rule: buffered plus in-flight bytes never exceed the 3 buffer slots.
    assign fifo_rdreq = enable & ~fifo_rdempty & (({1'b0, occ} + {2'b00, pend}) < 3'd3);
    assign m_valid    = (occ != 2'd0);
    assign m_data     = buf_mem[rd_ptr][9:2];
    assign m_sof      = buf_mem[rd_ptr][1];
    assign m_eof      = buf_mem[rd_ptr][0];
    assign pop        = m_valid & m_ready;
    assign last       = (remaining == 8'd1);
    assign fsm_state  = state;

    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) begin
            state <= HUNT;
            pend  <= 1'b0;
        end else begin
            state <= state_next;
            pend  <= fifo_rdreq;
        end
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        ok_set     = 1'b0;
        bad_frame  = 1'b0;
        discard    = 1'b0;
        load_len   = 1'b0;
        if (pend) begin
            case (state)
                HUNT: begin
                    if (fifo_q == SYNC_BYTE) state_next = LEN;
                    else                     discard    = 1'b1;
                end
                LEN: begin
                    if (fifo_q == 8'd0 || fifo_q > MAX_LEN_B) begin
                        bad_frame  = 1'b1;
                        state_next = HUNT;
                    end else begin
                        load_len   = 1'b1;
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    push = 1'b1;
                    if (last) begin
`ifdef CMPFIFO_RD_CSUM_EN
                        state_next = CSUM;
`else
                        ok_set     = 1'b1;
                        state_next = HUNT;
`endif
                    end
                end
`ifdef CMPFIFO_RD_CSUM_EN
                CSUM: begin
                    if (fifo_q == sum) ok_set    = 1'b1;
                    else               bad_frame = 1'b1;
                    state_next = HUNT;
                end
`endif
                default: state_next = HUNT;
            endcase
        end
    end

    // Frame bookkeeping: pulses are registered so they appear the cycle after the deciding byte.
    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) begin
            remaining <= '0;
            first     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
`ifdef CMPFIFO_RD_CSUM_EN
            sum       <= '0;
`endif
        end else begin
            frame_ok  <= ok_set;
            frame_err <= bad_frame;
            if (load_len) begin
                remaining <= fifo_q;
                first     <= 1'b1;
            end else if (push) begin
                remaining <= remaining - 8'd1;
                first     <= 1'b0;
            end
`ifdef CMPFIFO_RD_CSUM_EN
            if (load_len)  sum <= '0;
            else if (push) sum <= sum + fifo_q;
`endif
            if (ok_set) frame_cnt <= frame_cnt + 16'd1;
            if ((discard | bad_frame) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    // Three-entry circular output buffer of {data, sof, eof}.
    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= {fifo_q, first, last};
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: doc/comparator_fifo_reader.md
# comparator_fifo_reader

Read-side drain engine for the comparator's dual-clock capture FIFO (8-bit words, non-showahead). It sits entirely in the FIFO read clock domain. It pulls bytes with correct one-cycle read latency and parses them into framed records (sync, length, payload, checksum). Payload bytes are delivered downstream on a valid/ready stream with start/end markers, and per-frame status pulses and counters are kept.

## Interface
- SYNC_BYTE, 8'hA5, frame sync marker
- MAX_LEN, 255, largest legal payload length (1..255)
- rdclk  in  1  FIFO read clock, sole clock of the block
- aclr  in  1  asynchronous reset, active-high
- enable  in  1  allows new FIFO reads when high
- fifo_rdempty  in  1  FIFO read-side empty flag
- fifo_q  in  8  FIFO read data; valid the cycle after fifo_rdreq
- fifo_rdreq  out  1  FIFO read request
- m_data  out  8  payload byte
- m_valid  out  1  m_data/m_sof/m_eof valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_sof  out  1  first payload byte of frame
- m_eof  out  1  last payload byte of frame
- frame_ok  out  1  one-cycle pulse, frame passed
- frame_err  out  1  one-cycle pulse, frame failed
- frame_cnt  out  16  good frames, wraps
- err_cnt  out  16  bad frames plus discarded non-sync bytes, saturates at 16'hFFFF

## Operation
- Reset values: fifo_rdreq, m_valid, m_sof, m_eof, frame_ok, frame_err = 0. m_data = 8'h00. Both counters = 0. FSM = HUNT. Buffer and pending flag are cleared.
- Read issue: fifo_rdreq = enable & ~fifo_rdempty & (occ + pend < 3). occ is the output buffer occupancy (0..3). pend is 1 when last cycle's fifo_rdreq was high.
- Capture: when pend = 1, fifo_q is taken in that cycle and processed by the FSM.
- FSM acts only on captured bytes:
  - HUNT: byte == SYNC_BYTE goes to LEN. Any other byte is discarded and err_cnt increments.
  - LEN: byte is 0 or > MAX_LEN: frame_err pulses, err_cnt increments, return to HUNT. Otherwise load remaining = byte, clear sum, go to PAYLOAD.
  - PAYLOAD: push {byte, sof = first, eof = (remaining == 1)} into the 3-entry output buffer. sum = sum + byte (mod 256). Decrement remaining. When remaining reaches 0, go to CSUM.
  - CSUM: byte == sum gives frame_ok and frame_cnt + 1. Otherwise frame_err and err_cnt + 1. Either way, go to HUNT.
- Sync, length and checksum bytes never enter the output buffer.
- Output: m_* present the buffer head, which is popped on m_valid & m_ready. A simultaneous push and pop leaves occ unchanged.
- Status pulses are independent of the stream handshake. They can occur before the frame's m_eof byte is accepted downstream.
- enable low: no new fifo_rdreq is issued. A pending read still completes and is processed. The FSM holds its state.
- Back-pressure: the credit rule guarantees the buffer never overflows, so no payload byte is dropped.
- aclr mid-frame: all state is cleared immediately. Any byte already read from the FIFO and any partial frame are lost. After release, parsing restarts in HUNT.

## Timing
- fifo_rdreq high in cycle t; fifo_q sampled in t+1. If that byte is payload and the buffer was empty, m_valid is high in t+2 (2-cycle latency).
- Checksum byte captured in cycle c: frame_ok or frame_err is high in c+1 only, and the counter updates at the same edge.
- Sustained throughput is 1 byte/cycle with m_ready held high and the FIFO non-empty. With m_ready low, at most 3 bytes are buffered plus 0 in flight, and fifo_rdreq stays low.
- fifo_rdreq is a combinational function of registered state plus fifo_rdempty and enable.

## Configuration
- CMPFIFO_RD_CSUM_EN defined: the CSUM state and the checksum compare are built as described above.
- CMPFIFO_RD_CSUM_EN undefined:
  - Frames have no checksum byte and the sum logic is removed.
  - frame_ok pulses and frame_cnt increments one cycle after the last payload byte is captured. The FSM then returns to HUNT.
  - frame_err arises only from a bad length.

## Test plan
- FIFO holds A5 03 11 22 33 66, m_ready = 1 → m_data 11/22/33 on consecutive cycles. m_sof on 11, m_eof on 33. frame_ok once, frame_cnt = 1.
- Same frame with checksum 67 → payload still delivered. frame_err pulse, err_cnt = 1, frame_cnt = 0.
- Bytes 00 FF A5 00 → err_cnt = 3 (two discards plus zero length). No m_valid, FSM back in HUNT.
- A5 08 plus 8 payload bytes plus checksum, m_ready = 0 for 10 cycles then 1 → fifo_rdreq stops after 3 buffered bytes. All 8 bytes come out in order with no loss. frame_ok once.
- enable dropped for 5 cycles mid-payload → no fifo_rdreq in that window. The pending byte is still delivered, and the frame completes OK after enable returns.
- aclr pulsed after the second payload byte → all outputs at reset values. The next A5 01 7E 7E yields a single-byte frame with m_sof = m_eof = 1 and frame_ok.
